// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single RV32I memory port between the instruction-fetch (IF)
// path and the load/store (LS) path. One access is in flight at a time:
// the winner's command is registered onto the mem_* outputs, loads and
// fetches wait READ_LATENCY cycles for memory data, and the result (or a
// store acknowledge) is returned to the owning requester as a one-cycle
// rvalid pulse.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN - when defined, contended requests alternate
//                        between LS and IF (first contested grant goes to
//                        LS). When undefined, LS always wins over IF.
//
// Parameters:
//   READ_LATENCY  cycles from memory command edge to valid mem_data_out (1..7)
//   FETCH_FUNCT3  funct3 driven for instruction fetches
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   if_req/if_addr                    fetch request and byte address
//   if_gnt/if_rvalid/if_rdata         fetch accept pulse, data-valid pulse, data
//   ls_req/ls_we/ls_funct3/ls_addr/ls_wdata
//                                     load/store request and command fields
//   ls_gnt/ls_rvalid/ls_rdata         LS accept pulse, data-valid/ack pulse, data
//   mem_wren/mem_funct3/mem_address/mem_data_in
//                                     registered memory command
//   mem_data_out                      memory read data
//   busy                              high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [2:0]  FETCH_FUNCT3 = 3'b010
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [2:0]  ls_funct3,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,

    output logic        mem_wren,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,

    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [2:0] LAT_C = 3'(READ_LATENCY);

    state_t     state_r;
    logic [2:0] cnt_r;
    logic       win_ls_r;   // 1 = current access belongs to LS
    logic       win_we_r;   // 1 = current access is a store
    logic       pick_ls_s;  // arbitration result for this IDLE cycle

`ifdef ARB_ROUND_ROBIN_EN
    logic       last_grant_r;  // 0 = IF granted most recently, 1 = LS
`endif

    // Arbitration: decide which requester wins if the FSM samples now.
    always_comb begin
        pick_ls_s = 1'b0;
        if (ls_req && if_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            // Contention goes to whoever was not granted last.
            pick_ls_s = ~last_grant_r;
`else
            pick_ls_s = 1'b1;
`endif
        end else if (ls_req) begin
            pick_ls_s = 1'b1;
        end else begin
            pick_ls_s = 1'b0;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Round-robin history: remember the most recent grant winner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_r <= 1'b0;
        end else if (state_r == ST_IDLE && (if_req || ls_req)) begin
            last_grant_r <= pick_ls_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

    // Main access FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 3'd0;
            win_ls_r    <= 1'b0;
            win_we_r    <= 1'b0;
            if_gnt      <= 1'b0;
            if_rvalid   <= 1'b0;
            if_rdata    <= 32'h0000_0000;
            ls_gnt      <= 1'b0;
            ls_rvalid   <= 1'b0;
            ls_rdata    <= 32'h0000_0000;
            mem_wren    <= 1'b0;
            mem_funct3  <= 3'b000;
            mem_address <= 32'h0000_0000;
            mem_data_in <= 32'h0000_0000;
            busy        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if_gnt    <= 1'b0;
                    ls_gnt    <= 1'b0;
                    if_rvalid <= 1'b0;
                    ls_rvalid <= 1'b0;
                    mem_wren  <= 1'b0;
                    if (if_req || ls_req) begin
                        state_r  <= ST_ACCESS;
                        busy     <= 1'b1;
                        win_ls_r <= pick_ls_s;
                        if (pick_ls_s) begin
                            ls_gnt      <= 1'b1;
                            win_we_r    <= ls_we;
                            mem_wren    <= ls_we;
                            mem_funct3  <= ls_funct3;
                            mem_address <= ls_addr;
                            mem_data_in <= ls_wdata;
                        end else begin
                            if_gnt      <= 1'b1;
                            win_we_r    <= 1'b0;
                            mem_wren    <= 1'b0;
                            mem_funct3  <= FETCH_FUNCT3;
                            mem_address <= if_addr;
                            mem_data_in <= 32'h0000_0000;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end

                ST_ACCESS: begin
                    // Command has been presented for exactly one cycle.
                    if_gnt   <= 1'b0;
                    ls_gnt   <= 1'b0;
                    mem_wren <= 1'b0;
                    busy     <= 1'b1;
                    if (win_ls_r && win_we_r) begin
                        // Stores need no read data: acknowledge right away.
                        state_r   <= ST_RESP;
                        ls_rvalid <= 1'b1;
                    end else begin
                        state_r <= ST_WAIT;
                        cnt_r   <= LAT_C;
                    end
                end

                ST_WAIT: begin
                    busy <= 1'b1;
                    if (cnt_r <= 3'd1) begin
                        // Last latency cycle: memory data is valid now.
                        cnt_r   <= 3'd0;
                        state_r <= ST_RESP;
                        if (win_ls_r) begin
                            ls_rdata  <= mem_data_out;
                            ls_rvalid <= 1'b1;
                        end else begin
                            if_rdata  <= mem_data_out;
                            if_rvalid <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end

                ST_RESP: begin
                    if_rvalid <= 1'b0;
                    ls_rvalid <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end

                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= 3'd0;
                    if_gnt    <= 1'b0;
                    ls_gnt    <= 1'b0;
                    if_rvalid <= 1'b0;
                    ls_rvalid <= 1'b0;
                    mem_wren  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // DUT with READ_LATENCY = 1
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic        mem_wren, busy;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_address, mem_data_in, mem_data_out;

    // DUT with READ_LATENCY = 3
    logic        if3_req, if3_gnt, if3_rvalid;
    logic [31:0] if3_addr, if3_rdata;
    logic        ls3_req, ls3_we, ls3_gnt, ls3_rvalid;
    logic [2:0]  ls3_funct3;
    logic [31:0] ls3_addr, ls3_wdata, ls3_rdata;
    logic        mem3_wren, busy3;
    logic [2:0]  mem3_funct3;
    logic [31:0] mem3_address, mem3_data_in, mem3_data_out;

    mem_port_arbiter #(.READ_LATENCY(1), .FETCH_FUNCT3(3'b010)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_funct3(ls_funct3),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_wren(mem_wren), .mem_funct3(mem_funct3),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .busy(busy)
    );

    mem_port_arbiter #(.READ_LATENCY(3), .FETCH_FUNCT3(3'b010)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .if_req(if3_req), .if_addr(if3_addr), .if_gnt(if3_gnt),
        .if_rvalid(if3_rvalid), .if_rdata(if3_rdata),
        .ls_req(ls3_req), .ls_we(ls3_we), .ls_funct3(ls3_funct3),
        .ls_addr(ls3_addr), .ls_wdata(ls3_wdata), .ls_gnt(ls3_gnt),
        .ls_rvalid(ls3_rvalid), .ls_rdata(ls3_rdata),
        .mem_wren(mem3_wren), .mem_funct3(mem3_funct3),
        .mem_address(mem3_address), .mem_data_in(mem3_data_in),
        .mem_data_out(mem3_data_out), .busy(busy3)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        ls_req;
        logic        ls_we;
        logic [2:0]  ls_f3;
        logic [31:0] ls_addr;
        logic [31:0] ls_wdata;
        logic [31:0] mdo;
        logic        e_if_gnt;
        logic        e_if_rv;
        logic [31:0] e_if_rdata;
        logic        e_ls_gnt;
        logic        e_ls_rv;
        logic [31:0] e_ls_rdata;
        logic        e_wren;
        logic [2:0]  e_f3;
        logic [31:0] e_addr;
        logic [31:0] e_din;
        logic        e_busy;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int t_ls, t_if, ngnt, rv_seen;
        logic [3:0] order;
        logic [3:0] exp_order;

        reset_n = 1'b0;
        if_req = 1'b0; if_addr = 32'h0; ls_req = 1'b0; ls_we = 1'b0;
        ls_funct3 = 3'b000; ls_addr = 32'h0; ls_wdata = 32'h0; mem_data_out = 32'h0;
        if3_req = 1'b0; if3_addr = 32'h0; ls3_req = 1'b0; ls3_we = 1'b0;
        ls3_funct3 = 3'b000; ls3_addr = 32'h0; ls3_wdata = 32'h0; mem3_data_out = 32'h0;

        // fetch 0x1000 / store 0x2004 / load 0x2008 (IF req ignored while WAIT)
        vecs[0]  = '{1'b0, 32'h0,         1'b0, 1'b0, 3'b000, 32'h0,    32'h0,         32'h0,
                     1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 3'b000, 32'h0,    32'h0,         1'b0};
        vecs[1]  = '{1'b1, 32'h0000_1000, 1'b0, 1'b0, 3'b000, 32'h0,    32'h0,         32'h0,
                     1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 3'b010, 32'h1000, 32'h0,         1'b1};
        vecs[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 3'b000, 32'h0,    32'h0,         32'h0,
                     1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 3'b010, 32'h1000, 32'h0,         1'b1};
        vecs[3]  = '{1'b0, 32'h0,         1'b0, 1'b0, 3'b000, 32'h0,    32'h0,         32'h0050_0093,
                     1'b0, 1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0,         1'b0, 3'b010, 32'h1000, 32'h0,         1'b1};
        vecs[4]  = '{1'b0, 32'h0,         1'b0, 1'b0, 3'b000, 32'h0,    32'h0,         32'h0,
                     1'b0, 1'b0, 32'h0050_0093, 1'b0, 1'b0, 32'h0,         1'b0, 3'b010, 32'h1000, 32'h0,         1'b0};
        vecs[5]  = '{1'b0, 32'h0,         1'b1, 1'b1, 3'b010, 32'h2004, 32'hDEAD_BEEF, 32'h0,
                     1'b0, 1'b0, 32'h0050_0093, 1'b1, 1'b0, 32'h0,         1'b1, 3'b010, 32'h2004, 32'hDEAD_BEEF, 1'b1};
        vecs[6]  = '{1'b0, 32'h0,         1'b0, 1'b0, 3'b000, 32'h0,    32'h0,         32'h0,
                     1'b0, 1'b0, 32'h0050_0093, 1'b0, 1'b1, 32'h0,         1'b0, 3'b010, 32'h2004, 32'hDEAD_BEEF, 1'b1};
        vecs[7]  = '{1'b0, 32'h0,         1'b0, 1'b0, 3'b000, 32'h0,    32'h0,         32'h0,
                     1'b0, 1'b0, 32'h0050_0093, 1'b0, 1'b0, 32'h0,         1'b0, 3'b010, 32'h2004, 32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 3'b100, 32'h2008, 32'h0,         32'h0,
                     1'b0, 1'b0, 32'h0050_0093, 1'b1, 1'b0, 32'h0,         1'b0, 3'b100, 32'h2008, 32'h0,         1'b1};
        vecs[9]  = '{1'b1, 32'h0000_3000, 1'b0, 1'b0, 3'b000, 32'h0,    32'h0,         32'h0,
                     1'b0, 1'b0, 32'h0050_0093, 1'b0, 1'b0, 32'h0,         1'b0, 3'b100, 32'h2008, 32'h0,         1'b1};
        vecs[10] = '{1'b0, 32'h0,         1'b0, 1'b0, 3'b000, 32'h0,    32'h0,         32'hCAFE_F00D,
                     1'b0, 1'b0, 32'h0050_0093, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 3'b100, 32'h2008, 32'h0,         1'b1};
        vecs[11] = '{1'b0, 32'h0,         1'b0, 1'b0, 3'b000, 32'h0,    32'h0,         32'h0,
                     1'b0, 1'b0, 32'h0050_0093, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0, 3'b100, 32'h2008, 32'h0,         1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_busy3", {31'd0, busy3}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Table-driven main function
        for (int i = 0; i < 12; i++) begin
            if_req = vecs[i].if_req;   if_addr = vecs[i].if_addr;
            ls_req = vecs[i].ls_req;   ls_we = vecs[i].ls_we;
            ls_funct3 = vecs[i].ls_f3; ls_addr = vecs[i].ls_addr;
            ls_wdata = vecs[i].ls_wdata; mem_data_out = vecs[i].mdo;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_if_gnt", i),    {31'd0, if_gnt},    {31'd0, vecs[i].e_if_gnt});
            chk($sformatf("v%0d_if_rvalid", i), {31'd0, if_rvalid}, {31'd0, vecs[i].e_if_rv});
            chk($sformatf("v%0d_if_rdata", i),  if_rdata,           vecs[i].e_if_rdata);
            chk($sformatf("v%0d_ls_gnt", i),    {31'd0, ls_gnt},    {31'd0, vecs[i].e_ls_gnt});
            chk($sformatf("v%0d_ls_rvalid", i), {31'd0, ls_rvalid}, {31'd0, vecs[i].e_ls_rv});
            chk($sformatf("v%0d_ls_rdata", i),  ls_rdata,           vecs[i].e_ls_rdata);
            chk($sformatf("v%0d_mem_wren", i),  {31'd0, mem_wren},  {31'd0, vecs[i].e_wren});
            chk($sformatf("v%0d_mem_funct3", i), {29'd0, mem_funct3}, {29'd0, vecs[i].e_f3});
            chk($sformatf("v%0d_mem_address", i), mem_address,      vecs[i].e_addr);
            chk($sformatf("v%0d_mem_data_in", i), mem_data_in,      vecs[i].e_din);
            chk($sformatf("v%0d_busy", i),      {31'd0, busy},      {31'd0, vecs[i].e_busy});
        end
        if_req = 1'b0; ls_req = 1'b0; mem_data_out = 32'h0;

        // Reset in the middle of a store's ACCESS cycle
        ls_req = 1'b1; ls_we = 1'b1; ls_funct3 = 3'b010;
        ls_addr = 32'h0000_2000; ls_wdata = 32'h55AA_55AA;
        @(posedge clk);
        #1;
        chk("mid_gnt", {31'd0, ls_gnt}, 32'h1);
        chk("mid_wren_before", {31'd0, mem_wren}, 32'h1);
        ls_req = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mid_wren_after", {31'd0, mem_wren}, 32'h0);
        chk("mid_busy", {31'd0, busy}, 32'h0);
        chk("mid_ls_gnt", {31'd0, ls_gnt}, 32'h0);
        chk("mid_mem_address", mem_address, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rv_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (ls_rvalid === 1'b1) rv_seen++;
        end
        chk("mid_no_rvalid", rv_seen, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'h0);
        chk("post_rst_ls_rdata", ls_rdata, 32'h0);
        chk("post_rst_mem_data_in", mem_data_in, 32'h0);

        // Contention: both asserted at the same edge, each held until granted
        ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h0000_2020; ls_wdata = 32'h0;
        if_addr = 32'h0000_1004;
        if_req = 1'b1; ls_req = 1'b1;
        t_ls = -1; t_if = -1;
        for (int c = 1; c <= 30 && t_if < 0; c++) begin
            @(posedge clk);
            #1;
            if (ls_gnt === 1'b1) begin t_ls = c; ls_req = 1'b0; end
            if (if_gnt === 1'b1) begin t_if = c; if_req = 1'b0; end
        end
        if_req = 1'b0; ls_req = 1'b0;
        chk("cont_ls_gnt_cycle", t_ls, 32'd1);
        chk("cont_if_gnt_cycle", t_if, 32'd5);

        // Both held continuously for four grants
        repeat (6) @(posedge clk);
        #1;
        ls_addr = 32'h0000_2030;
        if_req = 1'b1; ls_req = 1'b1;
        ngnt = 0; order = 4'b0000;
        for (int c = 0; c < 80 && ngnt < 4; c++) begin
            @(posedge clk);
            #1;
            if (ls_gnt === 1'b1 || if_gnt === 1'b1) begin
                order[ngnt] = ls_gnt;
                ngnt++;
            end
        end
        if_req = 1'b0; ls_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = 4'b0101;
`else
        exp_order = 4'b1111;
`endif
        chk("rr_grant_count", ngnt, 32'd4);
        chk("rr_grant_order", {28'd0, order}, {28'd0, exp_order});

        // READ_LATENCY = 3 load
        repeat (6) @(posedge clk);
        #1;
        ls3_req = 1'b1; ls3_we = 1'b0; ls3_funct3 = 3'b010;
        ls3_addr = 32'h0000_2010; ls3_wdata = 32'h0;
        mem3_data_out = 32'hBAD0_0000;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rl3_c%0d_busy", k), {31'd0, busy3}, {31'd0, (k <= 5)});
            chk($sformatf("rl3_c%0d_gnt", k), {31'd0, ls3_gnt}, {31'd0, (k == 1)});
            chk($sformatf("rl3_c%0d_rvalid", k), {31'd0, ls3_rvalid}, {31'd0, (k == 5)});
            if (k == 1) begin
                ls3_req = 1'b0;
                chk("rl3_mem_address", mem3_address, 32'h0000_2010);
            end
            if (k == 5) chk("rl3_ls_rdata", ls3_rdata, 32'h1234_5678);
            mem3_data_out = (k == 4) ? 32'h1234_5678 : (32'hBAD0_0000 | 32'(k));
        end
        chk("rl3_if_rvalid", {31'd0, if3_rvalid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
